// File: rtl/float_rcp_pkg.sv
// Shared constants for the float reciprocal unit: flag bit positions,
// exponent bias and the canonical quiet-NaN encoding.
package float_rcp_pkg;
  localparam int FLG_INV = 4;
  localparam int FLG_DBZ = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;
  localparam int NFLG    = 5;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // {exp, man} of the canonical qNaN in the low ew+mw bits (sign is 0)
  function automatic logic [63:0] qnan_bits(input int ew, input int mw);
    logic [63:0] one;
    one = 64'd1;
    return (((one << ew) - one) << mw) | (one << (mw - 1));
  endfunction
endpackage

// File: rtl/float_rcp_core.sv
// Combinational 1/a: classification, restoring mantissa reciprocal with
// guard+sticky, round-to-nearest-even, FTZ on inputs and results.
module float_rcp_core
  import float_rcp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   sign,
  input  logic [EXP_W-1:0]       exp,
  input  logic [MAN_W-1:0]       man,
  output logic [EXP_W+MAN_W+5:0] x
);
  localparam int B  = bias(EXP_W);
  localparam int RW = MAN_W + 3;
  localparam logic [EXP_W+MAN_W-1:0] QNAN = (EXP_W+MAN_W)'(qnan_bits(EXP_W, MAN_W));

  logic [RW-1:0]    den, rem;
  logic [MAN_W+1:0] q;
  logic             sticky, rnd, pow2;
  logic [MAN_W:0]   man_r;
  int               re;
  logic             osign;
  logic [EXP_W-1:0] oexp;
  logic [MAN_W-1:0] oman;
  logic [NFLG-1:0]  flg;

  // q = 2/(1.m) in [1,2): integer bit, MAN_W fraction bits, one guard bit
  always_comb begin
    den = RW'({1'b1, man});
    rem = RW'(1) << (MAN_W + 1);
    q   = '0;
    for (int i = MAN_W + 1; i >= 0; i--) begin
      if (rem >= den) begin
        q[i] = 1'b1;
        rem  = rem - den;
      end
      rem = rem << 1;
    end
    sticky = |rem;
    rnd    = q[0] & (sticky | q[1]);
    man_r  = {1'b0, q[MAN_W:1]} + (MAN_W+1)'(rnd);
  end

  always_comb begin
    pow2  = (man == '0);
    re    = pow2 ? (2*B - int'(exp)) : (2*B - int'(exp) - 1 + int'(man_r[MAN_W]));
    osign = sign;
    oexp  = EXP_W'(re);
    oman  = pow2 ? '0 : man_r[MAN_W-1:0];
    flg   = '0;
    if (exp == '0) begin
      oexp         = '1;
      oman         = '0;
      flg[FLG_DBZ] = 1'b1;
    end else if (exp == '1) begin
      if (man == '0) begin
        oexp = '0;
        oman = '0;
      end else begin
        osign        = 1'b0;
        {oexp, oman} = QNAN;
        flg[FLG_INV] = ~man[MAN_W-1];
      end
    end else if (re < 1) begin
      oexp         = '0;
      oman         = '0;
      flg[FLG_UNF] = 1'b1;
      flg[FLG_INX] = 1'b1;
    end else begin
      flg[FLG_INX] = ~pow2 & (q[0] | sticky);
    end
    flg[FLG_OVF] = 1'b0;
    x = {osign, oexp, oman, flg};
  end
endmodule

// File: rtl/float_rcp_pipe.sv
// Elastic reciprocal pipeline: combinational core then STAGES
// valid/ready registers with bubble collapsing and a tag sideband.
module float_rcp_pipe
  import float_rcp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   a_sign,
  input  logic [EXP_W-1:0]       a_exp,
  input  logic [MAN_W-1:0]       a_man,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W+5:0] x,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);
  localparam int XW = 1 + EXP_W + MAN_W + NFLG;

  logic [XW-1:0]                    core_x;
  logic [STAGES-1:0]                vld_pipe;
  logic [STAGES:0]                  rdy;
  logic [STAGES-1:0][XW-1:0]        dat;
  logic [STAGES-1:0][TAG_W-1:0]     tag;
  logic [STAGES-1:0]                src_v;
  logic [STAGES-1:0][XW-1:0]        src_d;
  logic [STAGES-1:0][TAG_W-1:0]     src_t;

  float_rcp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
    .sign (a_sign),
    .exp  (a_exp),
    .man  (a_man),
    .x    (core_x)
  );

  assign rdy[STAGES] = out_ready;
  assign src_v[0]    = in_valid;
  assign src_d[0]    = core_x;
  assign src_t[0]    = in_tag;

  // a stage can load when empty or when its entry leaves this cycle
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_rdy
      assign rdy[k] = ~vld_pipe[k] | rdy[k+1];
    end
    for (k = 1; k < STAGES; k++) begin : g_src
      assign src_v[k] = vld_pipe[k-1];
      assign src_d[k] = dat[k-1];
      assign src_t[k] = tag[k-1];
    end
  endgenerate

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      vld_pipe <= '0;
      dat      <= '0;
      tag      <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush)       vld_pipe[s] <= 1'b0;
        else if (rdy[s]) vld_pipe[s] <= src_v[s];
        if (rdy[s]) begin
          dat[s] <= src_d[s];
          tag[s] <= src_t[s];
        end
      end
    end
  end

  assign in_ready  = rdy[0] | flush;
  assign out_valid = vld_pipe[STAGES-1];
  assign x         = dat[STAGES-1];
  assign out_tag   = tag[STAGES-1];
  assign busy      = |vld_pipe;
endmodule

// File: tb/tb_float_rcp_pipe.sv
// Scoreboard bench for float_rcp_pipe (E8/M23, 3 stages): directed
// vectors, streaming with random back-pressure, full pipe, flush, reset.
module tb_float_rcp_pipe;
  localparam int EXP_W = 8, MAN_W = 23, STAGES = 3, TAG_W = 4;
  localparam int XW = 1 + EXP_W + MAN_W + 5;

  logic             aclk = 1'b0, arst_n = 1'b0, flush = 1'b0;
  logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [31:0]      a_word = '0;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic [XW-1:0]    x;

  float_rcp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .aclk(aclk), .arst_n(arst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_word[31]), .a_exp(a_word[30:23]), .a_man(a_word[22:0]), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .out_tag(out_tag), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0, errors = 0, n_pop = 0, cyc = 0, acc_cyc = 0;
  logic [XW+TAG_W-1:0] sb[$];
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // input word -> {result word, flags {inv,dbz,ovf,unf,inx}}
  localparam int NV = 16;
  logic [31:0]   vin  [NV] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h00000000,
                               32'h80000001, 32'h7F800000, 32'h7F800001, 32'h7FC00000,
                               32'h7F000000, 32'h3F800000, 32'hC0800000, 32'h40A00000,
                               32'hFF800000, 32'hFF7FFFFF, 32'h7E800000, 32'h7E800001};
  logic [XW-1:0] vexp [NV] = '{{32'h3F000000, 5'b00000}, {32'h3EAAAAAB, 5'b00001},
                               {32'h3F2AAAAB, 5'b00001}, {32'h7F800000, 5'b01000},
                               {32'hFF800000, 5'b01000}, {32'h00000000, 5'b00000},
                               {32'h7FC00000, 5'b10000}, {32'h7FC00000, 5'b00000},
                               {32'h00000000, 5'b00011}, {32'h3F800000, 5'b00000},
                               {32'hBE800000, 5'b00000}, {32'h3E4CCCCD, 5'b00001},
                               {32'h80000000, 5'b00000}, {32'h80000000, 5'b00011},
                               {32'h00800000, 5'b00000}, {32'h00000000, 5'b00011}};

  // drives one operand from just after a posedge; pushes expectation on transfer
  task automatic send(input int idx, input logic [TAG_W-1:0] t);
    bit ok = 0;
    a_word = vin[idx]; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge aclk);
    if (ok) begin
      sb.push_back({vexp[idx], t});
      acc_cyc = cyc;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge aclk);
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // monitor: handshake, stability under stall, scoreboard compare
  logic          prev_stall = 1'b0;
  logic [XW-1:0] prev_x;
  logic [TAG_W-1:0] prev_tag;
  always @(negedge aclk) begin
    logic [XW+TAG_W-1:0] e;
    if (!arst_n) prev_stall = 1'b0;
    else begin
      if (flush) chk("in_ready_flush", 64'(in_ready), 64'd1);
      else chk("in_ready", 64'(in_ready), 64'(!(sb.size() == STAGES && !out_ready)));
      if (prev_stall)
        chk("stall_hold", {26'd0, out_valid, x}, {26'd0, 1'b1, prev_x});
      if (prev_stall) chk("stall_tag", 64'(out_tag), 64'(prev_tag));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", {27'd0, x}, 64'd0 - 64'd1);
        else begin
          e = sb.pop_front();
          n_pop++;
          chk("result_x", 64'(x), 64'(e[XW+TAG_W-1:TAG_W]));
          chk("result_tag", 64'(out_tag), 64'(e[TAG_W-1:0]));
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_x     = x;
      prev_tag   = out_tag;
    end
  end

  bit stop;
  int pops0;

  initial begin
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(posedge aclk); #1 arst_n = 1'b1;
    @(posedge aclk); #1;

    // latency of a single operand into an empty pipe
    send(0, 4'd5);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge aclk);
    chk("latency", 64'(cyc - acc_cyc), 64'(STAGES));
    wait_empty("drain_first");
    @(posedge aclk); #1;

    // directed vectors back to back
    for (int i = 0; i < NV; i++) send(i, 4'(i));
    wait_empty("drain_directed");

    // stream of 10 with random back-pressure
    pops0 = n_pop;
    stop = 0;
    @(posedge aclk); #1;
    fork
      begin
        for (int i = 0; i < 10; i++) send((i * 7) % NV, 4'(i + 3));
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge aclk); #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_empty("drain_stream");
    chk("stream_count", 64'(n_pop - pops0), 64'd10);

    // fill the pipe while stalled, then accept+emit in the same cycle
    @(posedge aclk); #1 out_ready = 1'b0;
    send(1, 4'd1); send(2, 4'd2); send(3, 4'd3);
    @(negedge aclk);
    chk("full_busy", 64'(busy), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge aclk); #1 out_ready = 1'b1;
    send(4, 4'd4);
    out_ready = 1'b0;
    @(negedge aclk);
    chk("occupancy_kept", 64'(in_ready), 64'd0);

    // flush with three entries; the operand in the flush cycle is dropped
    @(posedge aclk); #1 flush = 1'b1; a_word = vin[5]; in_tag = 4'd9; in_valid = 1'b1;
    @(posedge aclk);
    sb.delete();
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    out_ready = 1'b1;
    repeat (5) @(negedge aclk);
    chk("flush_no_stale", 64'(out_valid), 64'd0);

    // asynchronous reset with two entries in flight
    @(posedge aclk); #1 out_ready = 1'b0;
    send(6, 4'd6); send(7, 4'd7);
    @(posedge aclk); #2 arst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    sb.delete();
    @(posedge aclk); #1 arst_n = 1'b1; out_ready = 1'b1;
    repeat (6) @(negedge aclk);
    chk("arst_no_stale", 64'(out_valid), 64'd0);

    // pipe works again after reset
    @(posedge aclk); #1;
    send(11, 4'd11); send(13, 4'd12);
    wait_empty("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
